// File: rtl/overlay_pkg.sv
// Shared definitions for the overlay beat stream: field offsets, beat width,
// and the frame-buffer writer state encoding.
package overlay_pkg;

  localparam int unsigned BEAT_W    = 54;
  localparam int unsigned MASK_HI   = 53;
  localparam int unsigned MASK_LO   = 50;
  localparam int unsigned FRAME_BIT = 49;
  localparam int unsigned ADDR_HI   = 48;
  localparam int unsigned ADDR_LO   = 32;
  localparam int unsigned PIXEL_HI  = 31;
  localparam int unsigned PIXEL_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FLIP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/overlay_fifo.sv
// Small synchronous FIFO for overlay beats; head is a combinational read of
// the oldest entry so the writer can inspect it before deciding to pop.
module overlay_fifo import overlay_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = BEAT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wp, rp;
  logic [AW:0]             cnt;
  logic                    do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/overlay_fb_writer.sv
// Turns overlay beats into byte-masked word writes into one of two frame
// buffers, dropping fully-masked beats and reporting per-frame write counts.
module overlay_fb_writer import overlay_pkg::*; #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 28,
  parameter logic [ADDR_W-1:0] FB0_BASE = 28'h000_0000,
  parameter logic [ADDR_W-1:0] FB1_BASE = 28'h002_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BEAT_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              enable,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              frame_done,
  output logic [16:0]       frame_words
);

  logic [BEAT_W-1:0] head;
  logic              full, empty, pop, load;
  wr_state_t         state, state_nxt;
  logic              cur_frame;
  logic [16:0]       word_cnt;

  logic [3:0]        head_mask;
  logic              head_frame;
  logic [16:0]       head_addr;
  logic [ADDR_W-1:0] head_waddr;

  assign head_mask  = head[MASK_HI:MASK_LO];
  assign head_frame = head[FRAME_BIT];
  assign head_addr  = head[ADDR_HI:ADDR_LO];
  assign head_waddr = (head_frame ? FB1_BASE : FB0_BASE) + ADDR_W'(head_addr);
  assign din_ready  = !full;

  overlay_fifo #(.DEPTH(DEPTH), .W(BEAT_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (din_valid),
    .wdata   (din),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    load          = 1'b0;
    mem_req_valid = 1'b0;
    frame_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && enable) begin
          if (head_frame != cur_frame) begin
            state_nxt = ST_FLIP;
          end else if (head_mask == 4'd0) begin
            pop = 1'b1;
          end else begin
            pop       = 1'b1;
            load      = 1'b1;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = ST_IDLE;
      end
      ST_FLIP: begin
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // frame_words is captured on entry to FLIP so it is already valid during
  // the frame_done cycle; word_cnt cannot move while waiting there.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cur_frame   <= 1'b1;
      word_cnt    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      frame_words <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mem_addr  <= head_waddr;
        mem_wdata <= head[PIXEL_HI:PIXEL_LO];
        mem_wmask <= head_mask;
      end
      if (state == ST_REQ && mem_req_ready && word_cnt != 17'h1FFFF)
        word_cnt <= word_cnt + 17'd1;
      if (state == ST_IDLE && state_nxt == ST_FLIP)
        frame_words <= word_cnt;
      if (state == ST_FLIP) begin
        cur_frame <= head_frame;
        word_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_overlay_fb_writer.sv
// Randomized and directed bench for overlay_fb_writer against a beat-level
// reference model that predicts the ordered stream of requests and flips.
module tb_overlay_fb_writer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [53:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        enable = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [27:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        frame_done;
  logic [16:0] frame_words;

  overlay_fb_writer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .enable        (enable),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .frame_done    (frame_done),
    .frame_words   (frame_words)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          flip;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [16:0] words;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   checks = 0, failures = 0;
  int   req_seen = 0, flips_seen = 0;
  bit   m_cur = 1'b1;
  int   m_cnt = 0;
  bit   rand_en = 1'b0;
  bit   prev_fd = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [53:0] mk(logic [3:0] m, bit f, logic [16:0] a, logic [31:0] p);
    return {m, f, a, p};
  endfunction

  // Reference: every accepted beat either announces a frame change (reporting
  // writes since the last change), is dropped, or becomes one write.
  function automatic void model_push(logic [53:0] b);
    ev_t e;
    bit  f = b[49];
    logic [3:0] m = b[53:50];
    if (f != m_cur) begin
      e.flip = 1'b1; e.addr = '0; e.data = '0; e.mask = '0; e.words = 17'(m_cnt);
      exp_q.push_back(e);
      m_cur = f;
      m_cnt = 0;
    end
    if (m != 4'd0) begin
      e.flip  = 1'b0;
      e.addr  = (f ? 28'h0020000 : 28'h0000000) + {11'd0, b[48:32]};
      e.data  = b[31:0];
      e.mask  = m;
      e.words = '0;
      exp_q.push_back(e);
      if (m_cnt < 17'h1FFFF) m_cnt++;
    end
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (frame_done) chk("fd_single", prev_fd, 0);
      prev_fd = frame_done;
      if (frame_done || (mem_req_valid && mem_req_ready)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {frame_done, mem_req_valid && mem_req_ready}, 2'b00);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ev_kind", {frame_done, mem_req_valid && mem_req_ready}, mon_e.flip ? 2'b10 : 2'b01);
          if (mon_e.flip) begin
            flips_seen++;
            chk("frame_words", frame_words, mon_e.words);
          end else begin
            req_seen++;
            chk("mem_addr", mem_addr, mon_e.addr);
            chk("mem_wdata", mem_wdata, mon_e.data);
            chk("mem_wmask", mem_wmask, mon_e.mask);
          end
        end
      end
      if (din_valid && din_ready) model_push(din);
    end else begin
      prev_fd = 1'b0;
    end
  end

  always @(posedge clock) begin
    if (rand_en) begin
      #1;
      enable        = ($urandom_range(0, 3) != 0);
      mem_req_ready = ($urandom_range(0, 4) >= 2);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic [53:0] b, input int bound, output bit acc);
    din = b;
    din_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < bound && !acc; i++) begin
      @(negedge clock);
      if (din_ready) acc = 1'b1;
      @(posedge clock); #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int i = 0;
    while (exp_q.size() != 0 && i < bound) begin cyc(1); i++; end
    chk("drain_empty", exp_q.size(), 0);
    cyc(2);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_din_ready"}, din_ready, 1);
    chk({tag, "_req_valid"}, mem_req_valid, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wmask"}, mem_wmask, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_words"}, frame_words, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk_reset_outs("rst");
    exp_q.delete();
    m_cur = 1'b1;
    m_cnt = 0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int r0, f0;
    bit rf;
    #2;
    do_reset();

    // Frame-1 beat right after reset: no flip, request in cycle N+2.
    enable = 1'b1; mem_req_ready = 1'b1;
    send(mk(4'hF, 1'b1, 17'h1D56C, 32'hA5A5_0001), 10, acc);
    chk("lat_acc", acc, 1);
    @(negedge clock); chk("lat_n1_valid", mem_req_valid, 0);
    @(negedge clock); chk("lat_n2_valid", mem_req_valid, 1);
    chk("lat_n2_addr", mem_addr, 28'h003D56C);
    chk("lat_n2_wmask", mem_wmask, 4'hF);
    cyc(1);
    drain(20);

    // Three frame-1 writes, then frame 0 (flip reports 3), then back to 1 (reports 1).
    f0 = flips_seen;
    for (int i = 0; i < 2; i++) send(mk(4'hF, 1'b1, 17'(i), 32'(i + 100)), 10, acc);
    send(mk(4'hF, 1'b0, 17'h00064, 32'h0202_0202), 10, acc);
    drain(30);
    send(mk(4'h3, 1'b1, 17'h00010, 32'h1234_5678), 10, acc);
    drain(30);
    chk("flip_count", flips_seen - f0, 2);
    chk("flip_last_words", frame_words, 1);

    // Back-pressure: five beats absorbed (one in REQ + four queued), sixth blocked.
    mem_req_ready = 1'b0;
    r0 = req_seen;
    for (int i = 0; i < 5; i++) begin
      send(mk(4'(i + 1), 1'b1, 17'(16'h100 + i), 32'(32'hB000 + i)), 5, acc);
      chk("bp_acc", acc, 1);
    end
    send(mk(4'h9, 1'b1, 17'h00200, 32'hB0FF), 8, acc);
    chk("bp_block", acc, 0);
    chk("bp_din_ready", din_ready, 0);
    mem_req_ready = 1'b1;
    send(mk(4'h9, 1'b1, 17'h00200, 32'hB0FF), 20, acc);
    chk("bp_acc6", acc, 1);
    drain(40);
    chk("bp_reqs", req_seen - r0, 6);

    // Dropped beat between two writes; the following flip reports 2.
    do_reset();
    enable = 1'b1; mem_req_ready = 1'b1;
    r0 = req_seen;
    send(mk(4'hF, 1'b1, 17'h00001, 32'h1111_1111), 10, acc);
    send(mk(4'h0, 1'b1, 17'h00002, 32'h2222_2222), 10, acc);
    send(mk(4'hF, 1'b1, 17'h00003, 32'h3333_3333), 10, acc);
    send(mk(4'hF, 1'b0, 17'h1FFFF, 32'h4444_4444), 10, acc);
    drain(40);
    chk("mask_reqs", req_seen - r0, 3);
    chk("mask_frame_words", frame_words, 2);

    // Reset asserted between edges while a request waits with beats queued.
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(4'hC, 1'b0, 17'(i + 5), 32'(i)), 10, acc);
    cyc(3);
    chk("pre_rst_valid", mem_req_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    exp_q.delete();
    m_cur = 1'b1;
    m_cnt = 0;
    cyc(2);
    reset_n = 1'b1;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("post_rst_idle", mem_req_valid, 0);
    end
    cyc(1);

    // Randomized traffic with random enable and memory back-pressure.
    do_reset();
    rand_en = 1'b1;
    rf = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) rf = ~rf;
      send(mk(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), rf,
              17'($urandom), $urandom), 300, acc);
      if (!acc) chk("rand_acc", acc, 1);
      cyc($urandom_range(0, 2));
    end
    rand_en = 1'b0;
    cyc(1);
    enable = 1'b1;
    mem_req_ready = 1'b1;
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
